// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: walks the PC through instruction memory,
// resolves jumps internally and hands non-jump instructions to decode.
module instr_fetch_ctrl #(
  parameter int unsigned MEM_DEPTH = 32,
  parameter logic [7:0]  START_PC  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic [7:0] instr,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic       halted,
  output logic [7:0] deliver_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_LW   = 2'b01,
    OP_SW   = 2'b10,
    OP_JUMP = 2'b11
  } opcode_t;

  state_t     state, state_n;
  logic [7:0] pc, pc_n;
  logic [7:0] instr_n, instr_pc_n, deliver_cnt_n;
  logic       instr_valid_n;

  logic       handshake;
  logic       load_ok;
  logic       pc_in_range;
  logic       is_jump;
  logic [7:0] jump_offset;
  logic [7:0] jump_target;

  assign imem_addr   = pc;
  assign halted      = (state == HALT);

  assign handshake   = instr_valid && instr_ready;
  assign load_ok     = en && (!instr_valid || instr_ready);
  assign pc_in_range = 32'(pc) < MEM_DEPTH;
  assign is_jump     = opcode_t'(imem_data[7:6]) == OP_JUMP;
  assign jump_offset = {{2{imem_data[5]}}, imem_data[5:0]};
  assign jump_target = pc + 8'd1 + jump_offset;

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    instr_n       = instr;
    instr_pc_n    = instr_pc;
    instr_valid_n = instr_valid;
    deliver_cnt_n = deliver_cnt;

    // Acceptance is handled first so that a capture below overrides the clear.
    if (handshake) begin
      instr_valid_n = 1'b0;
      if (deliver_cnt != 8'hFF) begin
        deliver_cnt_n = deliver_cnt + 8'd1;
      end
    end

    unique case (state)
      IDLE: begin
        if (en) begin
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (!pc_in_range) begin
          state_n = HALT;
        end else if (en && is_jump) begin
          pc_n = jump_target;
        end else if (load_ok) begin
          instr_n       = imem_data;
          instr_pc_n    = pc;
          instr_valid_n = 1'b1;
          pc_n          = pc + 8'd1;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      deliver_cnt <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= instr_valid_n;
      deliver_cnt <= deliver_cnt_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural instruction memory.
module tb_instr_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       instr_ready;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       halted;
  logic [7:0] deliver_cnt;

  logic [7:0] mem [256];
  logic       bad_seen = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  always_comb imem_data = mem[imem_addr];

  instr_fetch_ctrl #(
    .MEM_DEPTH(32),
    .START_PC (8'h00)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .halted     (halted),
    .deliver_cnt(deliver_cnt)
  );

  // Skipped jump-over slots and the out-of-range PC must never reach decode.
  always @(negedge clk) begin
    if (!reset && instr_valid &&
        (instr_pc == 8'd19 || instr_pc == 8'd20 || instr_pc == 8'd32))
      bad_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 256; i++) mem[i] = (i < 32) ? 8'(i) : 8'h00;
    mem[0]  = 8'h65;
    mem[1]  = 8'h84;
    mem[18] = 8'h2D;
    mem[19] = 8'hC1;
    mem[20] = 8'h1A;
    mem[21] = 8'h45;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    instr_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    load_mem();
    do_reset();
    check_eq("rst_valid", 32'(instr_valid), 0);
    check_eq("rst_addr", 32'(imem_addr), 0);
    check_eq("rst_instr", 32'(instr), 0);
    check_eq("rst_instr_pc", 32'(instr_pc), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_cnt", 32'(deliver_cnt), 0);

    en = 1'b0;
    step();
    check_eq("idle_addr", 32'(imem_addr), 0);
    check_eq("idle_valid", 32'(instr_valid), 0);

    // Startup
    en = 1'b1;
    instr_ready = 1'b1;
    step();
    check_eq("enter_fetch_valid", 32'(instr_valid), 0);
    check_eq("enter_fetch_addr", 32'(imem_addr), 0);
    step();
    check_eq("first_instr", 32'(instr), 32'h65);
    check_eq("first_pc", 32'(instr_pc), 0);
    check_eq("first_valid", 32'(instr_valid), 1);
    check_eq("first_addr", 32'(imem_addr), 1);
    step();
    check_eq("second_instr", 32'(instr), 32'h84);
    check_eq("second_pc", 32'(instr_pc), 1);
    check_eq("second_cnt", 32'(deliver_cnt), 1);

    // Backpressure
    instr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("bp_instr", 32'(instr), 32'h84);
      check_eq("bp_addr", 32'(imem_addr), 2);
      check_eq("bp_cnt", 32'(deliver_cnt), 1);
    end
    instr_ready = 1'b1;
    step();
    check_eq("bp_release_pc", 32'(instr_pc), 2);
    check_eq("bp_release_instr", 32'(instr), 2);
    check_eq("bp_release_cnt", 32'(deliver_cnt), 2);

    // Streaming up to the forward jump
    for (int k = 3; k <= 18; k++) begin
      step();
      check_eq("stream_pc", 32'(instr_pc), 32'(k));
      check_eq("stream_instr", 32'(instr), (k == 18) ? 32'h2D : 32'(k));
      check_eq("stream_cnt", 32'(deliver_cnt), 32'(k));
    end
    check_eq("pre_jump_addr", 32'(imem_addr), 19);
    step();
    check_eq("jump_bubble_valid", 32'(instr_valid), 0);
    check_eq("jump_target_addr", 32'(imem_addr), 21);
    check_eq("jump_cnt", 32'(deliver_cnt), 19);
    step();
    check_eq("after_jump_instr", 32'(instr), 32'h45);
    check_eq("after_jump_pc", 32'(instr_pc), 21);
    check_eq("after_jump_addr", 32'(imem_addr), 22);

    // Range end
    for (int k = 22; k <= 31; k++) begin
      step();
      check_eq("tail_pc", 32'(instr_pc), 32'(k));
      check_eq("tail_cnt", 32'(deliver_cnt), 32'(k - 2));
    end
    check_eq("tail_addr", 32'(imem_addr), 32);
    check_eq("tail_not_halted", 32'(halted), 0);
    instr_ready = 1'b0;
    step();
    check_eq("halt_flag", 32'(halted), 1);
    check_eq("halt_pending_valid", 32'(instr_valid), 1);
    check_eq("halt_pending_pc", 32'(instr_pc), 31);
    check_eq("halt_addr", 32'(imem_addr), 32);
    step();
    check_eq("halt_hold_pc", 32'(instr_pc), 31);
    check_eq("halt_hold_cnt", 32'(deliver_cnt), 29);
    instr_ready = 1'b1;
    step();
    check_eq("halt_drain_valid", 32'(instr_valid), 0);
    check_eq("halt_drain_cnt", 32'(deliver_cnt), 30);
    step();
    check_eq("halt_stay", 32'(halted), 1);
    check_eq("halt_stay_valid", 32'(instr_valid), 0);
    check_eq("halt_stay_addr", 32'(imem_addr), 32);
    check_eq("skipped_never_valid", 32'(bad_seen), 0);

    // Reset out of HALT, then reset mid-transfer
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("halt_reset_halted", 32'(halted), 0);
    check_eq("halt_reset_cnt", 32'(deliver_cnt), 0);
    step();
    for (int i = 0; i < 6; i++) step();
    check_eq("mid_pc", 32'(instr_pc), 5);
    check_eq("mid_cnt", 32'(deliver_cnt), 5);
    instr_ready = 1'b0;
    step();
    check_eq("mid_hold_valid", 32'(instr_valid), 1);
    check_eq("mid_hold_cnt", 32'(deliver_cnt), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_valid", 32'(instr_valid), 0);
    check_eq("mid_rst_addr", 32'(imem_addr), 0);
    check_eq("mid_rst_cnt", 32'(deliver_cnt), 0);
    check_eq("mid_rst_halted", 32'(halted), 0);
    check_eq("mid_rst_instr", 32'(instr), 0);

    // Pause
    step();
    step();
    check_eq("pause_cap_instr", 32'(instr), 32'h65);
    step();
    check_eq("pause_hold_addr", 32'(imem_addr), 1);
    en = 1'b0;
    instr_ready = 1'b1;
    step();
    check_eq("pause_accept_valid", 32'(instr_valid), 0);
    check_eq("pause_accept_cnt", 32'(deliver_cnt), 1);
    check_eq("pause_accept_addr", 32'(imem_addr), 1);
    step();
    check_eq("pause_frozen_addr", 32'(imem_addr), 1);
    check_eq("pause_frozen_cnt", 32'(deliver_cnt), 1);
    check_eq("pause_frozen_valid", 32'(instr_valid), 0);
    en = 1'b1;
    step();
    check_eq("resume_instr", 32'(instr), 32'h84);
    check_eq("resume_pc", 32'(instr_pc), 1);
    check_eq("resume_addr", 32'(imem_addr), 2);

    // Backward jump, including a jump taken under backpressure
    mem[5] = 8'hFE;
    do_reset();
    en = 1'b1;
    instr_ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) step();
    check_eq("bwd_pre_pc", 32'(instr_pc), 4);
    check_eq("bwd_pre_addr", 32'(imem_addr), 5);
    step();
    check_eq("bwd_target", 32'(imem_addr), 4);
    check_eq("bwd_bubble", 32'(instr_valid), 0);
    step();
    check_eq("bwd_refetch_pc", 32'(instr_pc), 4);
    check_eq("bwd_refetch_addr", 32'(imem_addr), 5);
    instr_ready = 1'b0;
    step();
    check_eq("bwd_bp_jump_addr", 32'(imem_addr), 4);
    check_eq("bwd_bp_jump_valid", 32'(instr_valid), 1);
    step();
    check_eq("bwd_bp_hold_addr", 32'(imem_addr), 4);
    check_eq("bwd_bp_hold_pc", 32'(instr_pc), 4);
    check_eq("bwd_cnt", 32'(deliver_cnt), 5);

    // Jump landing outside memory
    mem[5] = 8'h05;
    mem[2] = 8'hDF;
    do_reset();
    en = 1'b1;
    instr_ready = 1'b1;
    step();
    step();
    step();
    step();
    check_eq("oor_target", 32'(imem_addr), 34);
    check_eq("oor_not_yet_halted", 32'(halted), 0);
    check_eq("oor_valid", 32'(instr_valid), 0);
    check_eq("oor_cnt", 32'(deliver_cnt), 2);
    step();
    check_eq("oor_halted", 32'(halted), 1);
    check_eq("oor_addr", 32'(imem_addr), 34);

    // Counter saturation: two-instruction loop delivers one per two cycles
    mem[2] = 8'h02;
    mem[1] = 8'hFE;
    do_reset();
    en = 1'b1;
    instr_ready = 1'b1;
    repeat (500) step();
    check_eq("sat_partial", 32'(deliver_cnt), 249);
    repeat (100) step();
    check_eq("sat_full", 32'(deliver_cnt), 32'hFF);
    check_eq("sat_not_halted", 32'(halted), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
